delay_detect: RTL and testbench

Delay recovery block at the receiving end of the `delay_15` path. It watches the reference bit stream and the same stream after an unknown delay of 0..15 cycles, and reports that delay. It holds lock while the streams keep matching and re-acquires after a mismatch or a restart. It sits beside a `delay_15` instance, or any external fixed delay, to calibrate or monitor it.

---
 rtl/delay_pkg.sv | 13 +
 rtl/delay_match_cnt.sv | 34 +++
 rtl/delay_detect.sv | 120 ++++++++++++
 tb/tb_delay_detect.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared constants and state type for the delay_15 / delay_detect pair.
package delay_pkg;

  localparam int DELAY_W   = 4;
  localparam int MAX_DELAY = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } delay_state_t;

endpackage

// File: rtl/delay_match_cnt.sv
// Saturating count of consecutive matches for one candidate delay.
module delay_match_cnt #(
  parameter int LOCK_CNT = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic match_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int            CW       = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] LOCK_VAL = CW'(LOCK_CNT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (!match_i) begin
        cnt_q <= '0;
      end else if (cnt_q != LOCK_VAL) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign hit_o = (cnt_q == LOCK_VAL);

endmodule

// File: rtl/delay_detect.sv
// Recovers the 0..15 cycle delay between a reference stream and its delayed copy,
// holds lock while they keep matching and re-acquires after a mismatch or start.
module delay_detect
  import delay_pkg::*;
#(
  parameter int LOCK_CNT = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               data_i,
  input  logic               data_delayed_i,
  input  logic               start_i,
  output logic [DELAY_W-1:0] delay_o,
  output logic               delay_val_o,
  output logic               lost_o,
  output delay_state_t       state_o
);

  localparam logic [DELAY_W-1:0] FILL_MAX = DELAY_W'(MAX_DELAY);

  delay_state_t       state_q;
  logic [MAX_DELAY-1:0] hist_q;
  logic [DELAY_W-1:0] fill_cnt;
  logic [MAX_DELAY:0] ref_bits;
  logic [MAX_DELAY:0] match_vec;
  logic [MAX_DELAY:0] elig_vec;
  logic [MAX_DELAY:0] hit_vec;
  logic               any_hit;
  logic [DELAY_W-1:0] win_d;
  logic               mismatch_lk;
  logic               cnt_clr;

  // Bit d of ref_bits is data_i delayed by d cycles (bit 0 is the live input).
  assign ref_bits    = {hist_q, data_i};
  assign match_vec   = ~(ref_bits ^ {(MAX_DELAY + 1){data_delayed_i}});
  assign mismatch_lk = (state_q == LOCKED) && !match_vec[delay_o];
  assign cnt_clr     = start_i || mismatch_lk;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[MAX_DELAY-2:0], data_i};
    end
  end

  for (genvar gi = 0; gi <= MAX_DELAY; gi++) begin : g_cand
    assign elig_vec[gi] = (state_q == SEARCH) && (fill_cnt >= DELAY_W'(gi));

    delay_match_cnt #(
      .LOCK_CNT(LOCK_CNT)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (elig_vec[gi]),
      .match_i(match_vec[gi]),
      .clr_i  (cnt_clr),
      .hit_o  (hit_vec[gi])
    );
  end

  // Scan from the top so the lowest hitting candidate is the last one written.
  always_comb begin
    any_hit = 1'b0;
    win_d   = '0;
    for (int d = MAX_DELAY; d >= 0; d--) begin
      if (hit_vec[d]) begin
        any_hit = 1'b1;
        win_d   = DELAY_W'(d);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      delay_o     <= '0;
      delay_val_o <= 1'b0;
      lost_o      <= 1'b0;
      fill_cnt    <= '0;
    end else begin
      lost_o <= 1'b0;
      if (start_i) begin
        state_q     <= SEARCH;
        delay_val_o <= 1'b0;
        fill_cnt    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          SEARCH: begin
            if (fill_cnt != FILL_MAX) begin
              fill_cnt <= fill_cnt + DELAY_W'(1);
            end
            if (any_hit) begin
              delay_o     <= win_d;
              delay_val_o <= 1'b1;
              state_q     <= LOCKED;
            end
          end
          LOCKED: begin
            if (mismatch_lk) begin
              lost_o      <= 1'b1;
              delay_val_o <= 1'b0;
              fill_cnt    <= '0;
              state_q     <= SEARCH;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_delay_detect.sv
// Bench for delay_detect: models the external delay line, predicts lock/loss from
// per-cycle stream records, and checks scenario timing in each test task.
module tb_delay_detect;
  import delay_pkg::*;

  localparam int L    = 8;
  localparam int MAXC = 4096;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               data_i;
  logic               data_delayed_i;
  logic               start_i;
  logic [DELAY_W-1:0] delay_o;
  logic               delay_val_o;
  logic               lost_o;
  delay_state_t       state_o;

  delay_detect #(.LOCK_CNT(L)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_i        (data_i),
    .data_delayed_i(data_delayed_i),
    .start_i       (start_i),
    .delay_o       (delay_o),
    .delay_val_o   (delay_val_o),
    .lost_o        (lost_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Stream records: din_a[c]/ddl_a[c] are the inputs seen at the edge closing cycle c.
  bit         din_a [MAXC];
  bit         ddl_a [MAXC];
  int         cyc       = -1;
  int         dly       = 0;
  int         data_mode = 0;   // 0: PRBS7, 1: constant 0, 2: random
  logic [6:0] lfsr;
  bit         inject    = 1'b0;

  // Reference model: mode 0 idle, 1 searching since cycle m_s, 2 locked.
  int               m_mode  = 0;
  int               m_s     = 0;
  logic             m_val   = 1'b0;
  logic             m_lost  = 1'b0;
  logic [DELAY_W-1:0] m_delay = '0;
  logic [5:0]       exp_q[$];
  logic [5:0]       sb_e;

  // Candidate d qualifies in cycle c when the last L cycles were all eligible matches.
  function automatic bit window_hit(int c, int d);
    if (c - L < m_s + d) return 1'b0;
    for (int j = c - L; j < c; j++) begin
      if (ddl_a[j] != din_a[j - d]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit start);
    bit b;
    bit dd;
    int found;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    case (data_mode)
      0: begin b = lfsr[6] ^ lfsr[5]; lfsr = {lfsr[5:0], b}; end
      1: b = 1'b0;
      default: b = 1'($urandom_range(0, 1));
    endcase
    din_a[cyc] = b;
    dd = (cyc - dly >= 0) ? din_a[cyc - dly] : 1'b0;
    if (inject) dd = ~dd;
    ddl_a[cyc]     = dd;
    data_i         = b;
    data_delayed_i = dd;
    start_i        = start;
    @(posedge clk_i);
    #1;
    m_lost = 1'b0;
    if (!rst_i) begin
      m_mode = 0; m_val = 1'b0; m_delay = '0;
    end else if (start) begin
      m_mode = 1; m_s = cyc + 1; m_val = 1'b0;
    end else if (m_mode == 1) begin
      found = -1;
      for (int d = MAX_DELAY; d >= 0; d--) if (window_hit(cyc, d)) found = d;
      if (found >= 0) begin
        m_mode = 2; m_val = 1'b1; m_delay = DELAY_W'(found);
      end
    end else if (m_mode == 2) begin
      if (ddl_a[cyc] != din_a[cyc - int'(m_delay)]) begin
        m_lost = 1'b1; m_val = 1'b0; m_mode = 1; m_s = cyc + 1;
      end
    end
    exp_q.push_back({m_val, m_lost, m_delay});
    start_i = 1'b0;
    inject  = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_val = 1'b0; m_lost = 1'b0; m_delay = '0;
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = '0;
  endtask

  task automatic drive_until_lock(output bit got);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      step(1'b0);
      if (delay_val_o === 1'b1) got = 1'b1;
    end
  endtask

  // Scoreboard: compare every cycle's outputs against the model, mid-cycle.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      checks++;
      if ({delay_val_o, lost_o, delay_o} !== sb_e) begin
        failures++;
        $display("FAIL model_cmp cyc=%0d got val=%b lost=%b delay=%0d exp val=%b lost=%b delay=%0d",
                 cyc + 1, delay_val_o, lost_o, delay_o, sb_e[5], sb_e[4], sb_e[3:0]);
      end
    end
  end

  task automatic test_reset();
    checks++;
    if ({delay_val_o, lost_o, delay_o} !== 6'd0) begin
      failures++;
      $display("FAIL reset_outputs got val=%b lost=%b delay=%0d exp 0/0/0", delay_val_o, lost_o, delay_o);
    end
    checks++;
    if (state_o !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", state_o, IDLE);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_idle_no_start();
    data_mode = 2;
    for (int n = 0; n < 40; n++) begin
      step(1'b0);
      checks++;
      if (state_o !== IDLE || delay_val_o !== 1'b0 || lost_o !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold n=%0d got state=%0d val=%b lost=%b exp IDLE/0/0", n, state_o, delay_val_o, lost_o);
      end
    end
  endtask

  // Lock rises on the (d+L+1)th edge after the start edge.
  task automatic test_sweep();
    data_mode = 0;
    for (int d = 0; d <= MAX_DELAY; d++) begin
      dly = d;
      step(1'b1);
      for (int n = 1; n <= d + L + 1; n++) begin
        step(1'b0);
        checks++;
        if (delay_val_o !== (n == d + L + 1) || lost_o !== 1'b0) begin
          failures++;
          $display("FAIL sweep_timing d=%0d n=%0d got val=%b lost=%b exp val=%b lost=0",
                   d, n, delay_val_o, lost_o, (n == d + L + 1));
        end
      end
      checks++;
      if (delay_o !== DELAY_W'(d)) begin
        failures++;
        $display("FAIL sweep_delay got=%0d exp=%0d", delay_o, d);
      end
    end
  endtask

  task automatic test_relock();
    bit got;
    int n_lost;
    int lost_cnt;
    int n_val;
    data_mode = 0;
    dly = 7;
    step(1'b1);
    drive_until_lock(got);
    checks++;
    if (!got || delay_o !== 4'd7) begin
      failures++;
      $display("FAIL relock_initial got lock=%b delay=%0d exp lock=1 delay=7", got, delay_o);
    end
    dly = 12;
    n_lost = -1;
    for (int n = 0; n < 60 && n_lost < 0; n++) begin
      step(1'b0);
      if (lost_o === 1'b1) n_lost = n;
    end
    checks++;
    if (n_lost < 0) begin
      failures++;
      $display("FAIL relock_lost_timeout got no lost pulse exp one within 60 cycles");
    end
    lost_cnt = 0;
    n_val = -1;
    for (int n = 1; n <= 30 && n_val < 0; n++) begin
      step(1'b0);
      if (lost_o === 1'b1) lost_cnt++;
      if (delay_val_o === 1'b1) n_val = n;
    end
    checks++;
    if (n_val != 12 + L + 1 || n_val > MAX_DELAY + L + 1 || delay_o !== 4'd12 || lost_cnt != 0) begin
      failures++;
      $display("FAIL relock_reacquire got after=%0d delay=%0d extra_lost=%0d exp after=%0d delay=12 extra_lost=0",
               n_val, delay_o, lost_cnt, 12 + L + 1);
    end
  endtask

  task automatic test_const_tie();
    data_mode = 1;
    dly = 9;
    for (int n = 0; n < 12; n++) step(1'b0);
    step(1'b1);
    for (int n = 1; n <= L + 1; n++) begin
      step(1'b0);
      checks++;
      if (delay_val_o !== (n == L + 1)) begin
        failures++;
        $display("FAIL const_timing n=%0d got val=%b exp=%b", n, delay_val_o, (n == L + 1));
      end
    end
    checks++;
    if (delay_o !== 4'd0) begin
      failures++;
      $display("FAIL const_tie_delay got=%0d exp=0", delay_o);
    end
  endtask

  task automatic test_reset_locked();
    bit got;
    data_mode = 0;
    dly = 3;
    step(1'b1);
    drive_until_lock(got);
    checks++;
    if (!got || delay_o !== 4'd3) begin
      failures++;
      $display("FAIL rstlk_initial got lock=%b delay=%0d exp lock=1 delay=3", got, delay_o);
    end
    rst_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({delay_val_o, lost_o, delay_o} !== 6'd0 || state_o !== IDLE) begin
      failures++;
      $display("FAIL rstlk_immediate got val=%b lost=%b delay=%0d state=%0d exp 0/0/0/IDLE",
               delay_val_o, lost_o, delay_o, state_o);
    end
    step(1'b0);
    rst_i = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step(1'b0);
      checks++;
      if (delay_val_o !== 1'b0 || lost_o !== 1'b0 || state_o !== IDLE) begin
        failures++;
        $display("FAIL rstlk_no_relock n=%0d got val=%b lost=%b state=%0d exp 0/0/IDLE",
                 n, delay_val_o, lost_o, state_o);
      end
    end
  endtask

  task automatic test_start_mismatch();
    bit got;
    data_mode = 0;
    dly = 3;
    step(1'b1);
    drive_until_lock(got);
    checks++;
    if (!got || delay_o !== 4'd3) begin
      failures++;
      $display("FAIL stmm_initial got lock=%b delay=%0d exp lock=1 delay=3", got, delay_o);
    end
    inject = 1'b1;
    step(1'b1);
    for (int n = 1; n <= 3 + L + 1; n++) begin
      step(1'b0);
      checks++;
      if (lost_o !== 1'b0 || delay_val_o !== (n == 3 + L + 1)) begin
        failures++;
        $display("FAIL stmm_timing n=%0d got val=%b lost=%b exp val=%b lost=0",
                 n, delay_val_o, lost_o, (n == 3 + L + 1));
      end
    end
    checks++;
    if (delay_o !== 4'd3) begin
      failures++;
      $display("FAIL stmm_delay got=%0d exp=3", delay_o);
    end
  endtask

  initial begin
    rst_i          = 1'b0;
    data_i         = 1'b0;
    data_delayed_i = 1'b0;
    start_i        = 1'b0;
    lfsr           = 7'($urandom_range(1, 127));
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    test_idle_no_start();
    test_sweep();
    test_relock();
    test_const_tie();
    test_reset_locked();
    test_start_mismatch();
    @(negedge clk_i);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
